// File: rtl/core_scheduler_pkg.sv
// Shared types and defaults for the matrix-multiplication core scheduler.
package core_scheduler_pkg;

    localparam int unsigned NUM_CORES_DEF = 3;
    localparam int unsigned JOB_W_DEF     = 8;

    // Per-core command encodings driven on status; 2'b11 is never used.
    localparam logic [1:0] STATUS_HOLD = 2'b00;
    localparam logic [1:0] STATUS_RUN  = 2'b01;
    localparam logic [1:0] STATUS_ACK  = 2'b10;

    typedef enum logic [1:0] {
        C_HOLD = 2'b00,
        C_RUN  = 2'b01,
        C_ACK  = 2'b10
    } core_state_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        FINISH = 2'b10
    } sched_state_t;

endpackage

// File: rtl/core_slot.sv
// One core's HOLD/RUN/ACK command FSM and its assigned job index register.
module core_slot
    import core_scheduler_pkg::*;
#(
    parameter int unsigned JOB_W = JOB_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             launch,
    input  logic [JOB_W-1:0] launch_job,
    input  logic             end_process,
    output logic [1:0]       status,
    output logic [JOB_W-1:0] job_id,
    output logic             hold_c,
    output logic             complete_c
);

    core_state_t state;

    // The state register is the status output, so the core command is glitch-free.
    assign status = 2'(state);

    always_comb begin
        hold_c     = (state == C_HOLD);
        complete_c = (state == C_RUN) && end_process;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= C_HOLD;
            job_id <= '0;
        end else begin
            case (state)
                C_HOLD: begin
                    if (launch) begin
                        state  <= C_RUN;
                        job_id <= launch_job;
                    end
                end
                C_RUN: begin
                    if (end_process) begin
                        state <= C_ACK;
                    end
                end
                C_ACK: begin
                    state <= C_HOLD;
                end
                default: begin
                    state <= C_HOLD;
                end
            endcase
        end
    end

endmodule

// File: rtl/core_scheduler.sv
// Dispatches a run of num_jobs jobs across NUM_CORES cores, round-robin over free cores.
module core_scheduler
    import core_scheduler_pkg::*;
#(
    parameter int unsigned NUM_CORES = NUM_CORES_DEF,
    parameter int unsigned JOB_W     = JOB_W_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [JOB_W-1:0]           num_jobs,
    input  logic [NUM_CORES-1:0]       end_process,
    output logic [2*NUM_CORES-1:0]     status,
    output logic [JOB_W*NUM_CORES-1:0] job_id,
    output logic                       busy,
    output logic                       done,
    output logic [JOB_W-1:0]           jobs_completed,
    output logic [15:0]                cycle_count
);

    localparam int unsigned PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    sched_state_t         state;
    logic [JOB_W-1:0]     num_jobs_lat;
    logic [JOB_W-1:0]     next_job;
    logic [PTR_W-1:0]     ptr;

    logic [NUM_CORES-1:0] hold_vec;
    logic [NUM_CORES-1:0] complete_vec;
    logic [NUM_CORES-1:0] launch_vec;
    logic                 found;
    logic [PTR_W-1:0]     target;
    logic                 launch_en;
    logic [JOB_W-1:0]     complete_cnt;
    logic                 finish;
    int unsigned          idx;

    // First HOLD core at or after the round-robin pointer, wrapping.
    always_comb begin
        found  = 1'b0;
        target = '0;
        idx    = 0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NUM_CORES) begin
                idx = idx - NUM_CORES;
            end
            if (!found && hold_vec[PTR_W'(idx)]) begin
                found  = 1'b1;
                target = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        launch_en  = (state == ACTIVE) && (next_job < num_jobs_lat) && found;
        launch_vec = '0;
        if (launch_en) begin
            launch_vec[target] = 1'b1;
        end
    end

    // Simultaneous completions are all counted in the same edge.
    always_comb begin
        complete_cnt = '0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            complete_cnt = complete_cnt + JOB_W'(complete_vec[k]);
        end
        finish = (jobs_completed == num_jobs_lat) && (&hold_vec);
    end

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_slot
        core_slot #(
            .JOB_W(JOB_W)
        ) u_slot (
            .clock      (clock),
            .reset      (reset),
            .launch     (launch_vec[i]),
            .launch_job (next_job),
            .end_process(end_process[i]),
            .status     (status[2*i +: 2]),
            .job_id     (job_id[JOB_W*i +: JOB_W]),
            .hold_c     (hold_vec[i]),
            .complete_c (complete_vec[i])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            num_jobs_lat   <= '0;
            next_job       <= '0;
            ptr            <= '0;
            jobs_completed <= '0;
            cycle_count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state          <= ACTIVE;
                        busy           <= 1'b1;
                        num_jobs_lat   <= num_jobs;
                        next_job       <= '0;
                        ptr            <= '0;
                        jobs_completed <= '0;
                        cycle_count    <= '0;
                    end
                end
                ACTIVE: begin
                    if (cycle_count != 16'hFFFF) begin
                        cycle_count <= cycle_count + 16'd1;
                    end
                    jobs_completed <= jobs_completed + complete_cnt;
                    if (launch_en) begin
                        next_job <= next_job + JOB_W'(1);
                        ptr      <= (target == PTR_W'(NUM_CORES - 1)) ? '0 : target + PTR_W'(1);
                    end
                    if (finish) begin
                        state <= FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_scheduler.sv
// Scoreboard bench for core_scheduler: expected events queued up front, monitor pops on each DUT event.
module tb_core_scheduler;

    localparam int NC = 3;
    localparam int JW = 8;

    localparam logic [31:0] K_SNAP   = 0;
    localparam logic [31:0] K_LAUNCH = 1;
    localparam logic [31:0] K_COMP   = 2;
    localparam logic [31:0] K_BUSY   = 3;
    localparam logic [31:0] K_DONE   = 4;

    typedef struct packed {
        logic [31:0] kind;
        logic [31:0] t;
        logic [31:0] f0;
        logic [31:0] f1;
        logic [31:0] f2;
        logic [31:0] f3;
        logic [31:0] f4;
    } ev_t;

    logic              clock;
    logic              reset;
    logic              start;
    logic [JW-1:0]     num_jobs;
    logic [NC-1:0]     end_process;
    logic [2*NC-1:0]   status;
    logic [JW*NC-1:0]  job_id;
    logic              busy;
    logic              done;
    logic [JW-1:0]     jobs_completed;
    logic [15:0]       cycle_count;

    ev_t         exp_q[$];
    int          snap_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic        mon_en   = 1'b0;
    logic [NC-1:0] force_ep = '0;
    int          dly[NC];

    core_scheduler #(.NUM_CORES(NC), .JOB_W(JW)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .num_jobs      (num_jobs),
        .end_process   (end_process),
        .status        (status),
        .job_id        (job_id),
        .busy          (busy),
        .done          (done),
        .jobs_completed(jobs_completed),
        .cycle_count   (cycle_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    function automatic string kname(input logic [31:0] k);
        case (k)
            K_SNAP:   return "snapshot";
            K_LAUNCH: return "launch";
            K_COMP:   return "jobs_completed";
            K_BUSY:   return "busy";
            K_DONE:   return "done";
            default:  return "unknown";
        endcase
    endfunction

    function automatic ev_t mk(input int k, input int t, input int a, input int b,
                               input int c, input int d, input int f);
        ev_t e;
        e.kind = 32'(k); e.t = 32'(t);
        e.f0 = 32'(a); e.f1 = 32'(b); e.f2 = 32'(c); e.f3 = 32'(d); e.f4 = 32'(f);
        return e;
    endfunction

    function automatic void ex(input int k, input int t, input int a = 0, input int b = 0,
                               input int c = 0, input int d = 0, input int f = 0);
        exp_q.push_back(mk(k, t, a, b, c, d, f));
    endfunction

    // Snapshot fields: status, jobs_completed, cycle_count, {busy,done}, job_id.
    function automatic void exs(input int t, input int st, input int jc, input int cc,
                                input int bd, input int jid);
        snap_q.push_back(t);
        ex(K_SNAP, t, st, jc, cc, bd, jid);
    endfunction

    function automatic void emit(input ev_t a);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_%s t=%0d got %0h,%0h,%0h,%0h,%0h required no event",
                     kname(a.kind), a.t, a.f0, a.f1, a.f2, a.f3, a.f4);
        end else begin
            e = exp_q.pop_front();
            if (a != e) begin
                failures++;
                $display("FAIL %s got kind=%s t=%0d f=%0h,%0h,%0h,%0h,%0h required kind=%s t=%0d f=%0h,%0h,%0h,%0h,%0h",
                         kname(e.kind), kname(a.kind), a.t, a.f0, a.f1, a.f2, a.f3, a.f4,
                         kname(e.kind), e.t, e.f0, e.f1, e.f2, e.f3, e.f4);
            end
        end
    endfunction

    // Monitor: turns DUT output changes into events, in a fixed per-cycle order.
    initial begin
        logic [1:0]    prev_st[NC];
        logic [JW-1:0] prev_jc;
        logic          prev_busy;
        logic [1:0]    st;
        int            am;
        for (int i = 0; i < NC; i++) prev_st[i] = 2'b00;
        prev_jc   = '0;
        prev_busy = 1'b0;
        wait (mon_en);
        forever begin
            @(posedge clock);
            #1;
            if (snap_q.size() > 0 && snap_q[0] == cyc) begin
                void'(snap_q.pop_front());
                emit(mk(K_SNAP, cyc, int'(status), int'(jobs_completed), int'(cycle_count),
                        int'({busy, done}), int'(job_id)));
            end
            am = 0;
            for (int i = 0; i < NC; i++) begin
                st = status[2*i +: 2];
                if (st == 2'b01 && prev_st[i] != 2'b01)
                    emit(mk(K_LAUNCH, cyc, i, int'(job_id[JW*i +: JW]), 0, 0, 0));
                if (prev_st[i] == 2'b10) begin
                    checks++;
                    if (st != 2'b00) begin
                        failures++;
                        $display("FAIL ack_to_hold core=%0d t=%0d got %b required 00", i, cyc, st);
                    end
                end
                if (st == 2'b10) am = am | (1 << i);
                prev_st[i] = st;
            end
            if (jobs_completed != prev_jc) emit(mk(K_COMP, cyc, int'(jobs_completed), am, 0, 0, 0));
            if (busy != prev_busy) emit(mk(K_BUSY, cyc, int'(busy), 0, 0, 0, 0));
            if (done) emit(mk(K_DONE, cyc, int'(jobs_completed), int'(cycle_count), 0, 0, 0));
            prev_jc   = jobs_completed;
            prev_busy = busy;
        end
    end

    // Core model: asserts end_process dly[i] cycles after the core enters RUN.
    initial begin
        int cnt[NC];
        logic [NC-1:0] ep;
        for (int i = 0; i < NC; i++) cnt[i] = 0;
        end_process = '0;
        forever begin
            @(negedge clock);
            #1;
            for (int i = 0; i < NC; i++) begin
                if (status[2*i +: 2] == 2'b01) begin
                    cnt[i]++;
                    ep[i] = (cnt[i] == dly[i]);
                end else begin
                    cnt[i] = 0;
                    ep[i]  = 1'b0;
                end
            end
            end_process = ep | force_ep;
        end
    end

    task automatic at(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    task automatic kick(input int n, output int s);
        @(negedge clock);
        start    = 1'b1;
        num_jobs = JW'(n);
        s        = cyc;
    endtask

    task automatic release_start();
        @(negedge clock);
        start    = 1'b0;
        num_jobs = '0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || snap_q.size() != 0) && n < 300) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || snap_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout got pending=%0d required 0", exp_q.size() + snap_q.size());
            exp_q.delete();
            snap_q.delete();
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic set_dly(input int a, input int b, input int c);
        dly[0] = a; dly[1] = b; dly[2] = c;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout got running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        reset    = 1'b1;
        start    = 1'b0;
        num_jobs = '0;
        set_dly(10, 10, 10);
        repeat (3) @(negedge clock);
        reset  = 1'b0;
        mon_en = 1'b1;
        exs(cyc + 1, 0, 0, 0, 0, 0);
        drain();

        // Basic run, three jobs on three cores.
        set_dly(10, 10, 10);
        kick(3, s);
        ex(K_BUSY, s+1, 1);
        ex(K_LAUNCH, s+2, 0, 0); ex(K_LAUNCH, s+3, 1, 1); ex(K_LAUNCH, s+4, 2, 2);
        ex(K_COMP, s+12, 1, 1); ex(K_COMP, s+13, 2, 2); ex(K_COMP, s+14, 3, 4);
        ex(K_BUSY, s+16, 0); ex(K_DONE, s+16, 3, 15);
        exs(s+18, 0, 3, 15, 0, 'h020100);
        release_start();
        drain();

        // Freed cores are reused: core 1 finishes first, then core 0.
        set_dly(9, 5, 20);
        kick(5, s);
        ex(K_COMP, s+1, 0, 0); ex(K_BUSY, s+1, 1);
        ex(K_LAUNCH, s+2, 0, 0); ex(K_LAUNCH, s+3, 1, 1); ex(K_LAUNCH, s+4, 2, 2);
        ex(K_COMP, s+8, 1, 2);
        ex(K_LAUNCH, s+10, 1, 3);
        ex(K_COMP, s+11, 2, 1);
        ex(K_LAUNCH, s+13, 0, 4);
        ex(K_COMP, s+15, 3, 2); ex(K_COMP, s+22, 4, 1); ex(K_COMP, s+24, 5, 4);
        ex(K_BUSY, s+26, 0); ex(K_DONE, s+26, 5, 25);
        release_start();
        drain();

        // All three cores complete on the same edge.
        set_dly(12, 11, 10);
        kick(3, s);
        ex(K_COMP, s+1, 0, 0); ex(K_BUSY, s+1, 1);
        ex(K_LAUNCH, s+2, 0, 0); ex(K_LAUNCH, s+3, 1, 1); ex(K_LAUNCH, s+4, 2, 2);
        ex(K_COMP, s+14, 3, 7);
        exs(s+15, 0, 3, 14, 2, 'h020100);
        ex(K_BUSY, s+16, 0); ex(K_DONE, s+16, 3, 15);
        release_start();
        drain();

        // Empty run.
        kick(0, s);
        ex(K_COMP, s+1, 0, 0); ex(K_BUSY, s+1, 1);
        ex(K_BUSY, s+2, 0); ex(K_DONE, s+2, 0, 1);
        exs(s+4, 0, 0, 1, 0, 'h020100);
        release_start();
        drain();

        // Spurious end_process on HOLD/ACK cores and start while ACTIVE are ignored.
        set_dly(10, 10, 10);
        kick(2, s);
        ex(K_BUSY, s+1, 1);
        ex(K_LAUNCH, s+2, 0, 0); ex(K_LAUNCH, s+3, 1, 1);
        ex(K_COMP, s+12, 1, 1); ex(K_COMP, s+13, 2, 2);
        ex(K_BUSY, s+15, 0); ex(K_DONE, s+15, 2, 14);
        release_start();
        at(s+5);
        force_ep = 3'b100; start = 1'b1; num_jobs = 8'd7;
        @(negedge clock);
        force_ep = 3'b000; start = 1'b0; num_jobs = '0;
        at(s+12);
        force_ep = 3'b001;
        @(negedge clock);
        force_ep = 3'b000;
        drain();

        // Reset mid-run beats start and end_process, then a fresh run completes.
        set_dly(10, 10, 30);
        kick(4, s);
        ex(K_COMP, s+1, 0, 0); ex(K_BUSY, s+1, 1);
        ex(K_LAUNCH, s+2, 0, 0); ex(K_LAUNCH, s+3, 1, 1); ex(K_LAUNCH, s+4, 2, 2);
        ex(K_COMP, s+12, 1, 1); ex(K_COMP, s+13, 2, 2);
        exs(s+14, 0, 0, 0, 0, 0);
        ex(K_COMP, s+14, 0, 0); ex(K_BUSY, s+14, 0);
        release_start();
        at(s+13);
        reset = 1'b1; start = 1'b1; num_jobs = 8'd9; force_ep = 3'b111;
        @(negedge clock);
        reset = 1'b0; start = 1'b0; num_jobs = '0; force_ep = 3'b000;
        drain();

        set_dly(10, 10, 10);
        kick(2, s);
        ex(K_BUSY, s+1, 1);
        ex(K_LAUNCH, s+2, 0, 0); ex(K_LAUNCH, s+3, 1, 1);
        ex(K_COMP, s+12, 1, 1); ex(K_COMP, s+13, 2, 2);
        ex(K_BUSY, s+15, 0); ex(K_DONE, s+15, 2, 14);
        release_start();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
